// File: rtl/mips_fetch.sv
// Instruction-fetch stage with IF/ID register: PC, delay-slot redirects, stall/flush, syscall halt.
// Optional FETCH_ALIGN_CHK_EN: misaligned redirect targets halt fetch and raise id_misaligned.
module mips_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic [5:0]  dcd_op,
    output logic [4:0]  dcd_rs,
    output logic [4:0]  dcd_rt,
    output logic [4:0]  dcd_rd,
    output logic [4:0]  dcd_shamt,
    output logic [5:0]  dcd_funct2,
    output logic [15:0] dcd_imm,
    output logic [25:0] dcd_target,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid,
    output logic        halted
`ifdef FETCH_ALIGN_CHK_EN
    ,
    output logic        id_misaligned
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] id_word_r, id_word_s;
    logic [31:0] id_pc_plus4_r, id_pc_plus4_s;
    logic        id_valid_r, id_valid_s;
    logic        halted_r, halted_s;
    logic        pend_valid_r, pend_valid_s;
    logic [31:0] pend_pc_r, pend_pc_s;
    logic [31:0] pc_plus4_s;
    logic        take_valid_s;
    logic [31:0] take_pc_s;
    logic        misalign_s;
`ifdef FETCH_ALIGN_CHK_EN
    logic        misaligned_r, misaligned_s;
`endif

    assign pc_plus4_s   = pc_r + 32'd4;
    // A live redirect beats one captured while stalled.
    assign take_valid_s = redirect_valid | pend_valid_r;
    assign take_pc_s    = redirect_valid ? redirect_pc : pend_pc_r;
`ifdef FETCH_ALIGN_CHK_EN
    assign misalign_s   = take_valid_s & (take_pc_s[1:0] != 2'b00);
`else
    assign misalign_s   = 1'b0;
`endif

    // Next-state and next-register computation; priority halt > stall > flush > normal.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        id_word_s     = id_word_r;
        id_pc_plus4_s = id_pc_plus4_r;
        id_valid_s    = id_valid_r;
        halted_s      = halted_r;
        pend_valid_s  = pend_valid_r;
        pend_pc_s     = pend_pc_r;
`ifdef FETCH_ALIGN_CHK_EN
        misaligned_s  = misaligned_r;
`endif
        case (state_r)
            BOOT, RUN: begin
                if (halt_req) begin
                    state_s      = HALT;
                    halted_s     = 1'b1;
                    id_valid_s   = 1'b0;
                    pend_valid_s = 1'b0;
                end else if (stall) begin
                    if (redirect_valid) begin
                        pend_valid_s = 1'b1;
                        pend_pc_s    = redirect_pc;
                    end else begin
                        pend_valid_s = pend_valid_r;
                    end
                end else if (misalign_s) begin
                    state_s      = HALT;
                    halted_s     = 1'b1;
                    id_valid_s   = 1'b0;
                    pend_valid_s = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
                    misaligned_s = 1'b1;
`endif
                end else begin
                    // The word fetched this cycle is the delay slot; only flush kills it.
                    state_s       = RUN;
                    id_word_s     = flush ? NOP_WORD : inst_data;
                    id_valid_s    = ~flush;
                    id_pc_plus4_s = pc_plus4_s;
                    pc_s          = take_valid_s ? (take_pc_s & 32'hFFFF_FFFC) : pc_plus4_s;
                    pend_valid_s  = 1'b0;
                end
            end
            HALT: begin
                id_valid_s = 1'b0;
                halted_s   = 1'b1;
            end
            default: begin
                state_s    = HALT;
                id_valid_s = 1'b0;
                halted_s   = 1'b1;
            end
        endcase
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= BOOT;
            pc_r          <= RESET_PC;
            id_word_r     <= NOP_WORD;
            id_pc_plus4_r <= 32'd0;
            id_valid_r    <= 1'b0;
            halted_r      <= 1'b0;
            pend_valid_r  <= 1'b0;
            pend_pc_r     <= 32'd0;
`ifdef FETCH_ALIGN_CHK_EN
            misaligned_r  <= 1'b0;
`endif
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            id_word_r     <= id_word_s;
            id_pc_plus4_r <= id_pc_plus4_s;
            id_valid_r    <= id_valid_s;
            halted_r      <= halted_s;
            pend_valid_r  <= pend_valid_s;
            pend_pc_r     <= pend_pc_s;
`ifdef FETCH_ALIGN_CHK_EN
            misaligned_r  <= misaligned_s;
`endif
        end
    end

    assign inst_addr   = pc_r;
    assign dcd_op      = id_word_r[31:26];
    assign dcd_rs      = id_word_r[25:21];
    assign dcd_rt      = id_word_r[20:16];
    assign dcd_rd      = id_word_r[15:11];
    assign dcd_shamt   = id_word_r[10:6];
    assign dcd_funct2  = id_word_r[5:0];
    assign dcd_imm     = id_word_r[15:0];
    assign dcd_target  = id_word_r[25:0];
    assign id_pc_plus4 = id_pc_plus4_r;
    assign id_valid    = id_valid_r;
    assign halted      = halted_r;
`ifdef FETCH_ALIGN_CHK_EN
    assign id_misaligned = misaligned_r;
`endif

endmodule

// File: tb/tb_mips_fetch.sv
// Directed vector bench for mips_fetch: table of single-cycle vectors plus hand sequences
// for decode fields, PC wrap, alignment handling, halt and mid-run reset.
module tb_mips_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        stall, flush, redirect_valid, halt_req;
    logic [31:0] redirect_pc;
    logic [5:0]  dcd_op, dcd_funct2;
    logic [4:0]  dcd_rs, dcd_rt, dcd_rd, dcd_shamt;
    logic [15:0] dcd_imm;
    logic [25:0] dcd_target;
    logic [31:0] id_pc_plus4;
    logic        id_valid, halted;
`ifdef FETCH_ALIGN_CHK_EN
    logic        id_misaligned;
`endif

    int n_vec = 0;
    int n_err = 0;

    mips_fetch dut (
        .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_data(inst_data),
        .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt_req(halt_req),
        .dcd_op(dcd_op), .dcd_rs(dcd_rs), .dcd_rt(dcd_rt), .dcd_rd(dcd_rd),
        .dcd_shamt(dcd_shamt), .dcd_funct2(dcd_funct2), .dcd_imm(dcd_imm),
        .dcd_target(dcd_target), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid),
        .halted(halted)
`ifdef FETCH_ALIGN_CHK_EN
        , .id_misaligned(id_misaligned)
`endif
    );

    always #5 clk = ~clk;

    // Combinational instruction memory: address-derived words, one known R-type word.
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0040_0100) return 32'h0085_1820;
        return {~a[15:0], a[15:0]};
    endfunction

    always_comb inst_data = mem(inst_addr);

    typedef struct {
        logic        rst, stall, flush, rv;
        logic [31:0] rpc;
        logic [31:0] e_addr, e_word, e_pc4;
        logic        e_valid;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic f, input logic rv,
                        input logic [31:0] rpc, input logic h);
        rst = r; stall = s; flush = f; redirect_valid = rv; redirect_pc = rpc; halt_req = h;
        @(posedge clk);
        #1;
        rst = 1'b0; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0040_0000, 32'h0, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0040_0004, mem(32'h0040_0000), 32'h0040_0004, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0040_0008, mem(32'h0040_0004), 32'h0040_0008, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0100, 32'h0040_0100, mem(32'h0040_0008), 32'h0040_000C, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0040_0104, 32'h0085_1820, 32'h0040_0104, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0040_0104, 32'h0085_1820, 32'h0040_0104, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0040_0200, 32'h0040_0104, 32'h0085_1820, 32'h0040_0104, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0040_0104, 32'h0085_1820, 32'h0040_0104, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0040_0200, mem(32'h0040_0104), 32'h0040_0108, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0040_0204, mem(32'h0040_0200), 32'h0040_0204, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0040_0204, mem(32'h0040_0200), 32'h0040_0204, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0040_0208, 32'h0, 32'h0040_0208, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0300, 32'h0040_0300, 32'h0, 32'h0040_020C, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0040_0400, 32'h0040_0300, 32'h0, 32'h0040_020C, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0500, 32'h0040_0500, mem(32'h0040_0300), 32'h0040_0304, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0040_0504, mem(32'h0040_0500), 32'h0040_0504, 1'b1};

        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; halt_req = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].rv, tbl[i].rpc, 1'b0);
            chk($sformatf("v%0d inst_addr", i), inst_addr, tbl[i].e_addr);
            chk($sformatf("v%0d id_word", i),
                {dcd_op, dcd_rs, dcd_rt, dcd_rd, dcd_shamt, dcd_funct2}, tbl[i].e_word);
            chk($sformatf("v%0d dcd_imm", i), {16'd0, dcd_imm}, {16'd0, tbl[i].e_word[15:0]});
            chk($sformatf("v%0d dcd_target", i), {6'd0, dcd_target}, {6'd0, tbl[i].e_word[25:0]});
            chk($sformatf("v%0d id_pc_plus4", i), id_pc_plus4, tbl[i].e_pc4);
            chk($sformatf("v%0d id_valid", i), {31'd0, id_valid}, {31'd0, tbl[i].e_valid});
            chk($sformatf("v%0d halted", i), {31'd0, halted}, 32'd0);
        end

        // Decode fields of 0x0085_1820 (add $3,$4,$5).
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0100, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("dec op", {26'd0, dcd_op}, 32'd0);
        chk("dec rs", {27'd0, dcd_rs}, 32'd4);
        chk("dec rt", {27'd0, dcd_rt}, 32'd5);
        chk("dec rd", {27'd0, dcd_rd}, 32'd3);
        chk("dec shamt", {27'd0, dcd_shamt}, 32'd0);
        chk("dec funct2", {26'd0, dcd_funct2}, 32'h20);
        chk("dec imm", {16'd0, dcd_imm}, 32'h1820);
        chk("dec target", {6'd0, dcd_target}, 32'h0085_1820);

        // PC+4 wraps at the top of the address space.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        chk("wrap pc", inst_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("wrap pc_plus4", id_pc_plus4, 32'h0);
        chk("wrap next pc", inst_addr, 32'h0);

`ifdef FETCH_ALIGN_CHK_EN
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0102, 1'b0);
        chk("align pc held", inst_addr, 32'h0);
        chk("align misaligned", {31'd0, id_misaligned}, 32'd1);
        chk("align halted", {31'd0, halted}, 32'd1);
        chk("align id_valid", {31'd0, id_valid}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("align sticky", {31'd0, id_misaligned}, 32'd1);
        chk("align pc frozen", inst_addr, 32'h0);
`else
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0102, 1'b0);
        chk("align forced low bits", inst_addr, 32'h0040_0100);
        chk("align not halted", {31'd0, halted}, 32'd0);
`endif

        // Halt, ignored redirect/stall, then reset recovers.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("pre-halt pc", inst_addr, 32'h0040_0004);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0040_0900, 1'b1);
        chk("halt halted", {31'd0, halted}, 32'd1);
        chk("halt id_valid", {31'd0, id_valid}, 32'd0);
        chk("halt pc", inst_addr, 32'h0040_0004);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0800, 1'b0);
        chk("halted redirect pc", inst_addr, 32'h0040_0004);
        chk("halted stays", {31'd0, halted}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("halted no pending", inst_addr, 32'h0040_0004);
        chk("halted id_valid", {31'd0, id_valid}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("reset pc", inst_addr, 32'h0040_0000);
        chk("reset halted", {31'd0, halted}, 32'd0);
        chk("reset id_valid", {31'd0, id_valid}, 32'd0);
        chk("reset pc_plus4", id_pc_plus4, 32'd0);
`ifdef FETCH_ALIGN_CHK_EN
        chk("reset misaligned", {31'd0, id_misaligned}, 32'd0);
`endif
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("post-reset id_valid", {31'd0, id_valid}, 32'd1);
        chk("post-reset pc", inst_addr, 32'h0040_0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
